uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- 8N1 UART receiver; the receive counterpart of the team's uart_tx, using the same CLKS_PER_BIT baud convention.
- Synchronises the asynchronous serial line, detects and validates the start bit, and samples each bit at its centre.
- Presents each received byte with a one-cycle valid pulse.
- Sits between the board RX pin and the SPI/UART configuration logic.

Parameters:
- CLKS_PER_BIT, 5208, i_Clock cycles per bit (50 MHz / 9600 baud). Legal range 4..65535.

Ports:
- i_Clock  input  1  system clock; all logic on its rising edge.
- i_Reset  input  1  asynchronous, active-high reset.
- i_Rx_Serial  input  1  asynchronous serial line; idles high.
- o_Rx_DV  output  1  one-cycle pulse: o_Rx_Byte holds a new valid byte.
- o_Rx_Byte  output  8  last correctly framed byte, LSB received first.
- o_Rx_Active  output  1  high while a frame is in progress (any state other than IDLE).
- o_Framing_Err  output  1  one-cycle pulse when the stop bit is sampled low.

Behaviour:
- Reset (asynchronous, i_Reset=1):
  - state = IDLE; counter and bit index = 0.
  - Synchroniser flops = 1 (line idle).
  - o_Rx_DV = 0, o_Framing_Err = 0, o_Rx_Active = 0, o_Rx_Byte = 8'h00.
  - Reset mid-frame abandons the frame; no DV or error pulse is generated.
- Input synchroniser:
  - 2-flop synchroniser on i_Rx_Serial, giving rx_s.
  - All decisions use rx_s, so there are 2 cycles of input latency.
- Counter: 16-bit clk_count, cleared on every state transition.
- Bit index: 3-bit, wraps 7 -> 0.
- IDLE: if rx_s=0, go to START.
- START:
  - When clk_count reaches (CLKS_PER_BIT-1)/2, sample rx_s.
  - rx_s=0: valid start bit; go to DATA. From here the counter runs from the bit centre.
  - rx_s=1: glitch; return to IDLE with no outputs.
- DATA:
  - When clk_count reaches CLKS_PER_BIT-1, store rx_s into shift_reg[bit_index].
  - If bit_index=7: clear bit_index and go to STOP. Otherwise increment bit_index.
- STOP:
  - When clk_count reaches CLKS_PER_BIT-1, sample rx_s.
  - rx_s=1: on the next edge, o_Rx_Byte <= shift_reg and o_Rx_DV=1 for exactly one cycle; go to CLEANUP.
  - rx_s=0: o_Framing_Err=1 for one cycle; o_Rx_Byte is unchanged; go to BREAK.
- BREAK: wait until rx_s=1, then go to IDLE. This prevents a held-low line (break) from retriggering the receiver.
- CLEANUP: one cycle, then IDLE.
- o_Rx_DV and o_Framing_Err are registered and never both high.
- Latency: DV rises about 2 + (CLKS_PER_BIT-1)/2 + 9*CLKS_PER_BIT + 1 cycles after the start edge on the pin, i.e. at the stop-bit centre.
- Back-to-back frames: a start edge is detected at the earliest 1 cycle after DV, since CLEANUP lasts one cycle. This is within the second half of the stop bit, so no frame is lost.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP, sampled at the bit centre.
  - Even parity: computed = XOR of the data bits. Adds port o_Parity_Err (output, 1 bit), a one-cycle pulse coincident with where DV would occur.
  - On mismatch, DV is suppressed, o_Rx_Byte is unchanged, and the FSM continues through STOP normally.
  - If both the parity bit and the stop bit are bad, only o_Framing_Err pulses.
- Undefined: no PARITY state and no o_Parity_Err port; frame format is 8N1.

Decomposition:
- Package uart_rx_pkg:
  - state_t enum: s_IDLE, s_START, s_DATA, s_PARITY, s_STOP, s_BREAK, s_CLEANUP. s_PARITY is always declared.
  - Constant DATA_BITS=8.
- Sub-module uart_rx_fsm (uart_rx_fsm.sv): next-state logic plus counter and bit-index control, parameterised by CLKS_PER_BIT.
- The top level holds the synchroniser, shift register, output registers and the state register.

Test Plan (CLKS_PER_BIT=8):
- Drive frame 0x37 (start, 1,1,1,0,1,1,0,0, stop) -> exactly one o_Rx_DV pulse; o_Rx_Byte=0x37; o_Framing_Err stays 0; o_Rx_Active high from about 3 cycles after the start edge until DV+1.
- Pull the line low for 2 cycles, then high -> no DV and no error; o_Rx_Active pulses briefly, then returns to IDLE.
- After a good 0x5A, send 0xA5 with the stop bit low and hold low for 20 cycles -> one o_Framing_Err pulse; no DV; o_Rx_Byte stays 0x5A; FSM in BREAK until the line rises.
- Send 0x00 then 0xFF back-to-back with no idle gap -> two DV pulses with bytes 0x00 and 0xFF in order.
- Assert i_Reset during bit 4 of a frame, then release and send 0xC3 -> no output during or after reset for the aborted frame; then DV with 0xC3.
- With UART_RX_PARITY_EN, send 0x01 with parity bit 0 -> o_Parity_Err pulse and no DV. Then send 0x01 with parity bit 1 -> DV with byte 0x01.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the uart_rx receiver.
// Optional even-parity support is enabled with the UART_RX_PARITY_EN macro.
package uart_rx_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        s_IDLE,
        s_START,
        s_DATA,
        s_PARITY,
        s_STOP,
        s_BREAK,
        s_CLEANUP
    } state_t;

    // Even parity: the transmitted parity bit equals the XOR of the data bits.
    function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_rx_fsm.sv
// Next-state logic, bit-period counter and bit index for uart_rx.
// Adds the PARITY bit period when UART_RX_PARITY_EN is defined.
module uart_rx_fsm
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  state_t     state_q,
    input  logic       rx_s,
    output state_t     state_d,
    output logic [2:0] bit_index,
    output logic       data_sample,
`ifdef UART_RX_PARITY_EN
    output logic       parity_sample,
`endif
    output logic       stop_sample
);

    localparam logic [15:0] HALF_COUNT = 16'((CLKS_PER_BIT - 1) / 2);
    localparam logic [15:0] LAST_COUNT = 16'(CLKS_PER_BIT - 1);
`ifdef UART_RX_PARITY_EN
    localparam state_t AFTER_DATA = s_PARITY;
`else
    localparam state_t AFTER_DATA = s_STOP;
`endif

    logic [15:0] clk_count_q, clk_count_d;
    logic [2:0]  bit_index_q, bit_index_d;

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            clk_count_q <= '0;
            bit_index_q <= '0;
        end else begin
            clk_count_q <= clk_count_d;
            bit_index_q <= bit_index_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        clk_count_d   = clk_count_q + 16'd1;
        bit_index_d   = bit_index_q;
        data_sample   = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_sample = 1'b0;
`endif
        stop_sample   = 1'b0;
        case (state_q)
            s_IDLE: begin
                clk_count_d = '0;
                bit_index_d = '0;
                if (!rx_s) state_d = s_START;
            end
            // Start bit is checked at its centre so later samples land mid-bit.
            s_START: begin
                if (clk_count_q == HALF_COUNT) begin
                    clk_count_d = '0;
                    state_d     = rx_s ? s_IDLE : s_DATA;
                end
            end
            s_DATA: begin
                if (clk_count_q == LAST_COUNT) begin
                    clk_count_d = '0;
                    data_sample = 1'b1;
                    bit_index_d = bit_index_q + 3'd1;
                    if (bit_index_q == 3'd7) state_d = AFTER_DATA;
                end
            end
            s_PARITY: begin
                if (clk_count_q == LAST_COUNT) begin
                    clk_count_d   = '0;
`ifdef UART_RX_PARITY_EN
                    parity_sample = 1'b1;
`endif
                    state_d       = s_STOP;
                end
            end
            s_STOP: begin
                if (clk_count_q == LAST_COUNT) begin
                    clk_count_d = '0;
                    stop_sample = 1'b1;
                    state_d     = rx_s ? s_CLEANUP : s_BREAK;
                end
            end
            // A held-low line must not be taken as a fresh start bit.
            s_BREAK: begin
                clk_count_d = '0;
                if (rx_s) state_d = s_IDLE;
            end
            s_CLEANUP: begin
                clk_count_d = '0;
                state_d     = s_IDLE;
            end
            default: begin
                clk_count_d = '0;
                state_d     = s_IDLE;
            end
        endcase
    end

    assign bit_index = bit_index_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: input synchroniser, shift register and registered outputs.
// Define UART_RX_PARITY_EN for 8E1 frames with an o_Parity_Err pulse.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_Rx_Serial,
    output logic       o_Rx_DV,
    output logic [7:0] o_Rx_Byte,
    output logic       o_Rx_Active,
`ifdef UART_RX_PARITY_EN
    output logic       o_Parity_Err,
`endif
    output logic       o_Framing_Err
);

    logic                 rx_meta_q, rx_s_q;
    state_t               state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] byte_q, byte_d;
    logic                 dv_q, dv_d;
    logic                 ferr_q, ferr_d;
    logic [2:0]           bit_index;
    logic                 data_sample, stop_sample;
`ifdef UART_RX_PARITY_EN
    logic                 parity_sample;
    logic                 parity_bad_q, parity_bad_d;
    logic                 perr_q, perr_d;
`endif

    uart_rx_fsm #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_fsm (
        .i_Clock      (i_Clock),
        .i_Reset      (i_Reset),
        .state_q      (state_q),
        .rx_s         (rx_s_q),
        .state_d      (state_d),
        .bit_index    (bit_index),
        .data_sample  (data_sample),
`ifdef UART_RX_PARITY_EN
        .parity_sample(parity_sample),
`endif
        .stop_sample  (stop_sample)
    );

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            rx_meta_q    <= 1'b1;
            rx_s_q       <= 1'b1;
            state_q      <= s_IDLE;
            shift_q      <= '0;
            byte_q       <= '0;
            dv_q         <= 1'b0;
            ferr_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bad_q <= 1'b0;
            perr_q       <= 1'b0;
`endif
        end else begin
            rx_meta_q    <= i_Rx_Serial;
            rx_s_q       <= rx_meta_q;
            state_q      <= state_d;
            shift_q      <= shift_d;
            byte_q       <= byte_d;
            dv_q         <= dv_d;
            ferr_q       <= ferr_d;
`ifdef UART_RX_PARITY_EN
            parity_bad_q <= parity_bad_d;
            perr_q       <= perr_d;
`endif
        end
    end

    always_comb begin
        shift_d = shift_q;
        byte_d  = byte_q;
        dv_d    = 1'b0;
        ferr_d  = 1'b0;
        if (data_sample) shift_d[bit_index] = rx_s_q;
`ifdef UART_RX_PARITY_EN
        perr_d       = 1'b0;
        parity_bad_d = parity_bad_q;
        if (state_q == s_IDLE) parity_bad_d = 1'b0;
        if (parity_sample) parity_bad_d = (rx_s_q != even_parity(shift_q));
`endif
        // A bad stop bit takes priority over any parity outcome.
        if (stop_sample) begin
            if (!rx_s_q) begin
                ferr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
            end else if (parity_bad_q) begin
                perr_d = 1'b1;
`endif
            end else begin
                dv_d   = 1'b1;
                byte_d = shift_q;
            end
        end
    end

    assign o_Rx_DV       = dv_q;
    assign o_Rx_Byte     = byte_q;
    assign o_Rx_Active   = (state_q != s_IDLE);
    assign o_Framing_Err = ferr_q;
`ifdef UART_RX_PARITY_EN
    assign o_Parity_Err  = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx at CLKS_PER_BIT = 8.
// Also exercises the parity path when UART_RX_PARITY_EN is defined.
module tb_uart_rx;

    localparam int CPB = 8;

    logic       clock = 1'b0;
    logic       reset;
    logic       rxSerial;
    logic       rxDv;
    logic [7:0] rxByte;
    logic       rxActive;
    logic       framingErr;
`ifdef UART_RX_PARITY_EN
    logic       parityErr;
    int         perrCount = 0;
`endif

    int         checks = 0;
    int         errors = 0;
    int         dvCount = 0;
    int         ferrCount = 0;
    int         overlapCount = 0;
    int         activeCycles = 0;
    logic [7:0] dvBytes [16];

    uart_rx #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .i_Clock      (clock),
        .i_Reset      (reset),
        .i_Rx_Serial  (rxSerial),
        .o_Rx_DV      (rxDv),
        .o_Rx_Byte    (rxByte),
        .o_Rx_Active  (rxActive),
`ifdef UART_RX_PARITY_EN
        .o_Parity_Err (parityErr),
`endif
        .o_Framing_Err(framingErr)
    );

    always #5 clock = ~clock;

    // Outputs are observed on the falling edge, half a cycle after they change.
    always @(negedge clock) begin
        if (rxDv) begin
            if (dvCount < 16) dvBytes[dvCount] = rxByte;
            dvCount++;
        end
        if (framingErr) ferrCount++;
        if (rxDv && framingErr) overlapCount++;
        if (rxActive) activeCycles++;
`ifdef UART_RX_PARITY_EN
        if (parityErr) perrCount++;
`endif
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drives one frame starting at a falling edge; reports the cycle at which
    // o_Rx_Active was first seen during the start bit (-1 if never).
    task automatic applyStimulus(input logic [7:0] data, input logic stopBit,
                                 input logic parityBit, output int activeDelay);
        activeDelay = -1;
        rxSerial = 1'b0;
        for (int i = 0; i < CPB; i++) begin
            @(negedge clock);
            if (activeDelay < 0 && rxActive) activeDelay = i + 1;
        end
        for (int b = 0; b < 8; b++) begin
            rxSerial = data[b];
            repeat (CPB) @(negedge clock);
        end
`ifdef UART_RX_PARITY_EN
        rxSerial = parityBit;
        repeat (CPB) @(negedge clock);
`else
        if (parityBit === 1'bx) rxSerial = 1'b1;
`endif
        rxSerial = stopBit;
        repeat (CPB) @(negedge clock);
    endtask

    initial begin
        int dvBase, ferrBase, actBase, delay;
        logic [7:0] abortData;
        reset    = 1'b1;
        rxSerial = 1'b1;
        repeat (3) @(negedge clock);
        checkOutput("reset_dv", 32'(rxDv), 32'd0);
        checkOutput("reset_byte", 32'(rxByte), 32'h00);
        checkOutput("reset_active", 32'(rxActive), 32'd0);
        checkOutput("reset_ferr", 32'(framingErr), 32'd0);
        reset = 1'b0;
        repeat (10) @(negedge clock);

        $display("[TB] good frame 0x37");
        dvBase = dvCount; ferrBase = ferrCount;
        applyStimulus(8'h37, 1'b1, ^8'h37, delay);
        repeat (5) @(negedge clock);
        checkOutput("f37_dv_count", 32'(dvCount - dvBase), 32'd1);
        checkOutput("f37_dv_byte", 32'(dvBytes[dvBase]), 32'h37);
        checkOutput("f37_out_byte", 32'(rxByte), 32'h37);
        checkOutput("f37_ferr", 32'(ferrCount - ferrBase), 32'd0);
        checkOutput("f37_active_delay", 32'(delay), 32'd3);
        checkOutput("f37_active_after", 32'(rxActive), 32'd0);

        $display("[TB] two-cycle glitch");
        dvBase = dvCount; ferrBase = ferrCount; actBase = activeCycles;
        rxSerial = 1'b0;
        repeat (2) @(negedge clock);
        rxSerial = 1'b1;
        repeat (20) @(negedge clock);
        checkOutput("glitch_dv", 32'(dvCount - dvBase), 32'd0);
        checkOutput("glitch_ferr", 32'(ferrCount - ferrBase), 32'd0);
        checkOutput("glitch_active_cycles", 32'(activeCycles - actBase), 32'd4);
        checkOutput("glitch_active_after", 32'(rxActive), 32'd0);

        $display("[TB] 0x5A then 0xA5 with low stop bit");
        dvBase = dvCount; ferrBase = ferrCount;
        applyStimulus(8'h5A, 1'b1, ^8'h5A, delay);
        repeat (10) @(negedge clock);
        checkOutput("f5a_dv_count", 32'(dvCount - dvBase), 32'd1);
        checkOutput("f5a_dv_byte", 32'(dvBytes[dvBase]), 32'h5A);
        applyStimulus(8'hA5, 1'b0, ^8'hA5, delay);
        repeat (20) @(negedge clock);
        checkOutput("ferr_count", 32'(ferrCount - ferrBase), 32'd1);
        checkOutput("ferr_no_dv", 32'(dvCount - dvBase), 32'd1);
        checkOutput("ferr_byte_kept", 32'(rxByte), 32'h5A);
        checkOutput("break_active", 32'(rxActive), 32'd1);
        rxSerial = 1'b1;
        repeat (10) @(negedge clock);
        checkOutput("break_released", 32'(rxActive), 32'd0);
        checkOutput("break_no_retrigger", 32'(ferrCount - ferrBase), 32'd1);

        $display("[TB] back-to-back 0x00 and 0xFF");
        dvBase = dvCount;
        applyStimulus(8'h00, 1'b1, ^8'h00, delay);
        applyStimulus(8'hFF, 1'b1, ^8'hFF, delay);
        repeat (10) @(negedge clock);
        checkOutput("b2b_dv_count", 32'(dvCount - dvBase), 32'd2);
        checkOutput("b2b_first", 32'(dvBytes[dvBase]), 32'h00);
        checkOutput("b2b_second", 32'(dvBytes[dvBase + 1]), 32'hFF);

        $display("[TB] reset during bit 4");
        dvBase = dvCount; ferrBase = ferrCount;
        abortData = 8'h96;
        rxSerial = 1'b0;
        repeat (CPB) @(negedge clock);
        for (int b = 0; b < 4; b++) begin
            rxSerial = abortData[b];
            repeat (CPB) @(negedge clock);
        end
        rxSerial = abortData[4];
        repeat (CPB / 2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checkOutput("midreset_active", 32'(rxActive), 32'd0);
        repeat (2) @(negedge clock);
        rxSerial = 1'b1;
        reset = 1'b0;
        repeat (20) @(negedge clock);
        checkOutput("midreset_no_dv", 32'(dvCount - dvBase), 32'd0);
        checkOutput("midreset_no_ferr", 32'(ferrCount - ferrBase), 32'd0);
        checkOutput("midreset_byte", 32'(rxByte), 32'h00);
        applyStimulus(8'hC3, 1'b1, ^8'hC3, delay);
        repeat (5) @(negedge clock);
        checkOutput("fc3_dv_count", 32'(dvCount - dvBase), 32'd1);
        checkOutput("fc3_byte", 32'(rxByte), 32'hC3);

`ifdef UART_RX_PARITY_EN
        $display("[TB] parity checks on 0x01");
        begin
            int perrBase;
            dvBase = dvCount; perrBase = perrCount;
            applyStimulus(8'h01, 1'b1, 1'b0, delay);
            repeat (5) @(negedge clock);
            checkOutput("par_bad_perr", 32'(perrCount - perrBase), 32'd1);
            checkOutput("par_bad_no_dv", 32'(dvCount - dvBase), 32'd0);
            checkOutput("par_bad_byte_kept", 32'(rxByte), 32'hC3);
            applyStimulus(8'h01, 1'b1, 1'b1, delay);
            repeat (5) @(negedge clock);
            checkOutput("par_good_dv", 32'(dvCount - dvBase), 32'd1);
            checkOutput("par_good_byte", 32'(rxByte), 32'h01);
            checkOutput("par_good_perr", 32'(perrCount - perrBase), 32'd1);
        end
`endif

        checkOutput("dv_ferr_overlap", 32'(overlapCount), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
